// File: rtl/z80_bus_master.sv
// Z80-timed bus cycle initiator: one command at a time over valid/ready, one-clock response strobe.
// Build option: define Z80_BUS_MASTER_WAIT_EN to honour bus_wait; otherwise cycle length is fixed.
module z80_bus_master #(
  parameter int TSTATE_CLKS = 8
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  output logic        bus_mreq,
  output logic        bus_iorq,
  output logic        bus_m1,
  output logic        bus_rfsh,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_wait
);

  localparam int CW = $clog2(TSTATE_CLKS);
  localparam logic [CW-1:0] T_END  = CW'(TSTATE_CLKS - 1);
  localparam logic [CW-1:0] T_HALF = CW'(TSTATE_CLKS / 2);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_e;
  typedef enum logic [2:0] {
    OP_MRD = 3'd0, OP_MWR = 3'd1, OP_IRD = 3'd2, OP_IWR = 3'd3, OP_FETCH = 3'd4
  } op_e;

  state_e          state, state_n;
  op_e             op, op_n;
  logic [CW-1:0]   tcnt, tcnt_n;
  logic [6:0]      r;
  logic [7:0]      fetch_q;
  logic            accept, t_end, is_io, wait_s, early, mid;
  logic            mreq_n, iorq_n, m1_n, rfsh_n, rd_n, wr_n, d_oe_n;

`ifdef Z80_BUS_MASTER_WAIT_EN
  assign wait_s = bus_wait;
`else
  logic unused_wait;
  assign unused_wait = bus_wait;
  assign wait_s      = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = (state == IDLE) && req_valid;
  assign t_end     = (tcnt == T_END);
  assign is_io     = (op == OP_IRD) || (op == OP_IWR);

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    op_n    = op;
    if (accept) begin
      state_n = T1;
      tcnt_n  = '0;
      op_n    = (req_op > 3'd4) ? OP_MRD : op_e'(req_op);
    end else if (state != IDLE) begin
      tcnt_n = t_end ? '0 : tcnt + CW'(1);
      if (t_end) begin
        case (state)
          T1:      state_n = T2;
          // IO always gets one TW; wait is only looked at from the last clock of T2/TW
          T2:      state_n = (is_io || wait_s) ? TW : T3;
          TW:      state_n = wait_s ? TW : T3;
          T3:      state_n = (op == OP_FETCH) ? T4 : IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Strobes decoded from the next state so they register in step with it
  always_comb begin
    early  = (state_n == T1) && (tcnt_n >= T_HALF);
    mid    = (state_n == T2) || (state_n == TW) || (state_n == T3);
    mreq_n = 1'b0;
    iorq_n = 1'b0;
    m1_n   = 1'b0;
    rfsh_n = 1'b0;
    rd_n   = 1'b0;
    wr_n   = 1'b0;
    d_oe_n = 1'b0;
    case (op_n)
      OP_MWR: begin
        mreq_n = early || mid;
        d_oe_n = early || mid;
        wr_n   = mid;
      end
      OP_IRD: begin
        iorq_n = mid;
        rd_n   = mid;
      end
      OP_IWR: begin
        iorq_n = mid;
        wr_n   = mid;
        d_oe_n = early || mid;
      end
      OP_FETCH: begin
        m1_n   = (state_n == T1) || (state_n == T2) || (state_n == TW);
        rd_n   = early || (state_n == T2) || (state_n == TW);
        rfsh_n = (state_n == T3) || (state_n == T4);
        mreq_n = rd_n || ((state_n == T3) && (tcnt_n >= T_HALF)) ||
                 ((state_n == T4) && (tcnt_n < T_HALF));
      end
      default: begin
        mreq_n = early || mid;
        rd_n   = early || mid;
      end
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_MRD;
      tcnt      <= '0;
      r         <= '0;
      fetch_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_a     <= '0;
      bus_d_out <= '0;
      bus_d_oe  <= 1'b0;
      bus_mreq  <= 1'b0;
      bus_iorq  <= 1'b0;
      bus_m1    <= 1'b0;
      bus_rfsh  <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      tcnt      <= tcnt_n;
      bus_mreq  <= mreq_n;
      bus_iorq  <= iorq_n;
      bus_m1    <= m1_n;
      bus_rfsh  <= rfsh_n;
      bus_rd    <= rd_n;
      bus_wr    <= wr_n;
      bus_d_oe  <= d_oe_n;
      rsp_valid <= (state != IDLE) && (state_n == IDLE);
      if (accept) begin
        bus_a     <= req_addr;
        bus_d_out <= req_wdata;
      end else if ((op == OP_FETCH) && (state == T2 || state == TW) && (state_n == T3)) begin
        // opcode captured as the fetch leaves T2/TW; refresh address goes out for T3-T4
        fetch_q <= bus_d_in;
        bus_a   <= {9'h000, r};
      end
      if ((state == T3) && (state_n == IDLE) && (op == OP_MRD || op == OP_IRD))
        rsp_rdata <= bus_d_in;
      if ((state == T4) && (state_n == IDLE)) begin
        rsp_rdata <= fetch_q;
        r         <= r + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Randomized bench for z80_bus_master: per-cycle strobe/address windows from T-state arithmetic.
module tb_z80_bus_master;
  localparam int N = 4;
  localparam int H = N / 2;
`ifdef Z80_BUS_MASTER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in = '0;
  logic        bus_mreq, bus_iorq, bus_m1, bus_rfsh, bus_rd, bus_wr;
  logic        bus_wait = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [6:0]  m_r = '0;
  logic [7:0]  m_rdata = '0;

  always #5 clk28 = ~clk28;

  z80_bus_master #(.TSTATE_CLKS(N)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
    .bus_mreq(bus_mreq), .bus_iorq(bus_iorq), .bus_m1(bus_m1), .bus_rfsh(bus_rfsh),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wait(bus_wait)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit wait_at(input int c, input int ws, input int wl);
    return (wl > 0) && (c >= ws) && (c < ws + wl);
  endfunction

  // Cycle 1 is the first clock after the accept edge; T-state i covers cycles i*N+1 .. (i+1)*N.
  // Strobe bits: 6 mreq, 5 iorq, 4 m1, 3 rfsh, 2 rd, 1 wr, 0 d_oe.
  task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] din, input int ws, input int wl, input string tag,
                        output int got_lat);
    int o, kind, nw, i3, s3, e2, e3, lat, smp, cyc, bad_s, bad_a, bad_d;
    int lo[7][2];
    int hi[7][2];
    logic [6:0]  ex_s, got_s;
    logic [15:0] ex_a;
    o    = (op > 3'd4) ? 0 : int'(op);
    kind = (o == 2 || o == 3) ? 1 : (o == 4) ? 2 : 0;
    nw   = (kind == 1) ? 1 : 0;
    while (WAIT_EN && wait_at((2 + nw) * N, ws, wl)) nw++;
    i3  = 2 + nw;
    s3  = i3 * N + 1;
    e2  = i3 * N;
    e3  = (i3 + 1) * N;
    lat = (i3 + 1 + ((kind == 2) ? 1 : 0)) * N + 1;
    smp = (kind == 2) ? e2 : e3;
    for (int k = 0; k < 7; k++)
      for (int j = 0; j < 2; j++) begin
        lo[k][j] = 1;
        hi[k][j] = 0;
      end
    case (o)
      1: begin
        lo[6][0] = H + 1; hi[6][0] = e3;
        lo[0][0] = H + 1; hi[0][0] = e3;
        lo[1][0] = N + 1; hi[1][0] = e3;
      end
      2: begin
        lo[5][0] = N + 1; hi[5][0] = e3;
        lo[2][0] = N + 1; hi[2][0] = e3;
      end
      3: begin
        lo[5][0] = N + 1; hi[5][0] = e3;
        lo[1][0] = N + 1; hi[1][0] = e3;
        lo[0][0] = H + 1; hi[0][0] = e3;
      end
      4: begin
        lo[4][0] = 1;      hi[4][0] = e2;
        lo[6][0] = H + 1;  hi[6][0] = e2;
        lo[2][0] = H + 1;  hi[2][0] = e2;
        lo[6][1] = s3 + H; hi[6][1] = s3 + N + H - 1;
        lo[3][0] = s3;     hi[3][0] = s3 + 2 * N - 1;
      end
      default: begin
        lo[6][0] = H + 1; hi[6][0] = e3;
        lo[2][0] = H + 1; hi[2][0] = e3;
      end
    endcase

    chk({tag, "_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    bus_wait  = 1'b0;
    @(posedge clk28);
    #1;
    // junk on the request port while busy must be ignored
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 8'($urandom);

    cyc = 0; bad_s = 0; bad_a = 0; bad_d = 0; got_lat = -1;
    while (got_lat < 0 && cyc < lat + 16) begin
      @(negedge clk28);
      cyc++;
      for (int k = 0; k < 7; k++)
        ex_s[k] = (cyc >= lo[k][0] && cyc <= hi[k][0]) || (cyc >= lo[k][1] && cyc <= hi[k][1]);
      ex_a  = (kind == 2 && cyc >= s3) ? {9'd0, m_r} : addr;
      got_s = {bus_mreq, bus_iorq, bus_m1, bus_rfsh, bus_rd, bus_wr, bus_d_oe};
      if (got_s !== ex_s) bad_s++;
      if (bus_a !== ex_a) bad_a++;
      if (bus_d_oe && bus_d_out !== wd) bad_d++;
      if (rsp_valid) got_lat = cyc;
      bus_wait = wait_at(cyc, ws, wl);
      bus_d_in = (cyc == smp) ? din : ~din;
    end

    if (o == 0 || o == 2 || o == 4) m_rdata = din;
    chk({tag, "_lat"}, got_lat, lat);
    chk({tag, "_strobes"}, bad_s, 0);
    chk({tag, "_addr"}, bad_a, 0);
    chk({tag, "_dout"}, bad_d, 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(m_rdata));
    if (kind == 2) m_r = m_r + 7'd1;
    req_valid = 1'b0;
  endtask

  initial begin
    int lat, seen, ws, wl, gap;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wd, din;

    repeat (3) @(negedge clk28);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_strobes", 32'({bus_mreq, bus_iorq, bus_m1, bus_rfsh, bus_rd, bus_wr, bus_d_oe}), 0);
    chk("rst_addr", 32'(bus_a), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
    rst_n = 1'b1;
    @(negedge clk28);
    chk("rel_ready", 32'(req_ready), 1);
    chk("rel_strobes", 32'({bus_mreq, bus_iorq, bus_m1, bus_rfsh, bus_rd, bus_wr, bus_d_oe}), 0);

    run_op(3'd0, 16'h5B00, 8'h00, 8'hA5, 0, 0, "mrd", lat);
    chk("mrd_lat13", lat, 13);
    @(negedge clk28);
    chk("mrd_pulse", 32'(rsp_valid), 0);
    run_op(3'd1, 16'h4000, 8'h3C, 8'h00, 0, 0, "mwr", lat);
    chk("mwr_lat13", lat, 13);
    @(negedge clk28);
    run_op(3'd2, 16'h00FE, 8'h00, 8'h77, 10, 5, "iord", lat);
    chk("iord_lat", lat, WAIT_EN ? 21 : 17);
    @(negedge clk28);
    // back-to-back fetches: each accept lands on the previous rsp_valid clock
    run_op(3'd4, 16'h8000, 8'h00, 8'h3E, 0, 0, "f0", lat);
    run_op(3'd4, 16'h8001, 8'h00, 8'h01, 0, 0, "f1", lat);
    run_op(3'd4, 16'h8002, 8'h00, 8'hC9, 0, 0, "f2", lat);
    chk("f2_lat17", lat, 17);

    // reset in T2 of a memory write
    req_valid = 1'b1; req_op = 3'd1; req_addr = 16'h4000; req_wdata = 8'h3C;
    @(posedge clk28);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clk28);
    chk("rst_pre_wr", 32'(bus_wr), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'({bus_wr, bus_mreq, bus_d_oe}), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk28);
      if (rsp_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk28);
      if (rsp_valid) seen++;
    end
    chk("rst_mid_no_rsp", seen, 0);
    chk("rst_mid_ready", 32'(req_ready), 1);
    chk("rst_mid_rdata", 32'(rsp_rdata), 0);
    m_r = '0;
    m_rdata = '0;
    run_op(3'd4, 16'h1234, 8'h00, 8'h5A, 0, 0, "f_after_rst", lat);

    for (int t = 0; t < 40; t++) begin
      op   = 3'($urandom);
      addr = 16'($urandom);
      wd   = 8'($urandom);
      din  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ws = int'($urandom_range(1, 24));
        wl = int'($urandom_range(1, 6));
      end else begin
        ws = 0;
        wl = 0;
      end
      run_op(op, addr, wd, din, ws, wl, "rnd", lat);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk28);
        chk("rnd_idle", 32'({rsp_valid, bus_mreq, bus_iorq, bus_rd, bus_wr, bus_d_oe}), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
